// File: rtl/stdout_uart.sv
// stdout_uart: snoops data-memory stores to the stdout word, queues the low byte of each
// matching store in a small FIFO and drains the queue on an 8N1 UART transmit line.
module stdout_uart #(
    parameter logic [31:0] STDOUT_ADDR    = 32'h0000_00fc,
    parameter int unsigned CLKS_PER_BIT   = 16,
    parameter int unsigned FIFO_DEPTH_LOG = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      we,
    input  logic [31:0]               wa,
    input  logic [31:0]               wd,
    output logic                      tx,
    output logic                      busy,
    output logic                      full,
    output logic [FIFO_DEPTH_LOG:0]   level,
    output logic [7:0]                overflow
);

    localparam int unsigned DEPTH   = 1 << FIFO_DEPTH_LOG;
    localparam int unsigned TIMER_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned LEVEL_W = FIFO_DEPTH_LOG + 1;

    localparam logic [TIMER_W-1:0]        TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [TIMER_W-1:0]        TIMER_ONE  = TIMER_W'(1);
    localparam logic [LEVEL_W-1:0]        LEVEL_FULL = LEVEL_W'(DEPTH);
    localparam logic [LEVEL_W-1:0]        LEVEL_ONE  = LEVEL_W'(1);
    localparam logic [FIFO_DEPTH_LOG-1:0] PTR_ONE    = FIFO_DEPTH_LOG'(1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e                    state_q, state_d;
    logic [TIMER_W-1:0]        timer_q, timer_d;
    logic [2:0]                index_q, index_d;
    logic [7:0]                shift_q, shift_d;
    logic                      tx_q, tx_d;
    logic [FIFO_DEPTH_LOG-1:0] rd_ptr_q, wr_ptr_q;
    logic [LEVEL_W-1:0]        level_q, level_d;
    logic [7:0]                overflow_q, overflow_d;
    logic [7:0]                mem [DEPTH];

    logic match, fifo_full, fifo_nonempty, timer_done;
    logic pop, push_ok, drop;

    // Address bits below word granularity and the upper data bytes are deliberately ignored.
    logic unused_bits;
    assign unused_bits = ^{wa[1:0], wd[31:8]};

    assign match         = we && (wa[31:2] == STDOUT_ADDR[31:2]);
    assign fifo_full     = (level_q == LEVEL_FULL);
    assign fifo_nonempty = (level_q != '0);
    assign timer_done    = (timer_q == TIMER_LAST);

    // Transmit FSM next-state, bit timing and FIFO pop decision.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + TIMER_ONE;
        index_d = index_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                timer_d = '0;
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    state_d = StStart;
                end
            end
            StStart: begin
                if (timer_done) begin
                    timer_d = '0;
                    index_d = 3'd0;
                    state_d = StData;
                end
            end
            StData: begin
                if (timer_done) begin
                    timer_d = '0;
                    shift_d = shift_q >> 1;
                    index_d = index_q + 3'd1;
                    if (index_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (timer_done) begin
                    timer_d = '0;
                    // Chain straight into the next start bit when more bytes are waiting.
                    if (fifo_nonempty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase
    end

    // Line level follows the next state so tx switches on the same edge as the FSM.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // FIFO occupancy and drop accounting; a pop frees the slot a same-cycle push needs.
    always_comb begin
        push_ok    = match && (!fifo_full || pop);
        drop       = match && fifo_full && !pop;
        level_d    = level_q;
        overflow_d = overflow_q;
        unique case ({push_ok, pop})
            2'b10:   level_d = level_q + LEVEL_ONE;
            2'b01:   level_d = level_q - LEVEL_ONE;
            default: level_d = level_q;
        endcase
        if (drop && (overflow_q != 8'hff)) begin
            overflow_d = overflow_q + 8'd1;
        end
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            index_q    <= 3'd0;
            shift_q    <= 8'h00;
            tx_q       <= 1'b1;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            index_q    <= index_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wd[7:0];
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != StIdle) || fifo_nonempty;
    assign full     = fifo_full;
    assign level    = level_q;
    assign overflow = overflow_q;

endmodule
